// File: rtl/neighbor_table_writer_if.sv
// Memory bus between neighbor_table_writer (master) and the neighbor-table RAM (slave).
// Handshake: no valid/ready. A write happens on every clock edge where wr_en=1. A read is
// implied by every presented address, and its word appears on data_in one cycle later.
interface neighbor_table_writer_if;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic [15:0] data_in;

  modport master (output address, output wr_en, output data_out, input data_in);
  modport slave  (input address, input wr_en, input data_out, output data_in);
endinterface

// File: rtl/neighbor_table_writer.sv
// Inserts or updates one neighbor record in a RAM-resident table: reads the count, scans IDs,
// then writes the fields. Optional qValue write is enabled by macro NBR_QVALUE_WRITE_EN.
module neighbor_table_writer (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          start,
  input  logic [15:0]                   nbr_id,
  input  logic [15:0]                   clus_id,
  input  logic [15:0]                   batt,
  input  logic [15:0]                   qval,
  neighbor_table_writer_if.master       mem,
  output logic                          done,
  output logic                          table_full,
  output logic [5:0]                    slot,
  output logic [3:0]                    state_dbg
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_CNT = 4'd1,
    SCAN   = 4'd2,
    WR_NID = 4'd3,
    WR_CID = 4'd4,
    WR_BAT = 4'd5,
    WR_QV  = 4'd6,
    WR_CNT = 4'd7,
    DONE   = 4'd8
  } state_t;

  localparam logic [10:0] NID_BASE = 11'h048;
  localparam logic [10:0] CID_BASE = 11'h0C8;
  localparam logic [10:0] BAT_BASE = 11'h148;
  localparam logic [10:0] QV_BASE  = 11'h1C8;
  localparam logic [10:0] CNT_ADDR = 11'h68A;

  state_t      state_q, state_d;
  logic        rd_ph_q, rd_ph_d;
  logic [6:0]  count_q, count_d;
  logic [6:0]  issue_q, issue_d;
  logic        cmp_vld_q, cmp_vld_d;
  logic [5:0]  cmp_idx_q, cmp_idx_d;
  logic        append_q, append_d;
  logic [5:0]  slot_q, slot_d;
  logic        full_q, full_d;
  logic [15:0] nbr_q, nbr_d;
  logic [15:0] cid_q, cid_d;
  logic [15:0] bat_q, bat_d;

`ifdef NBR_QVALUE_WRITE_EN
  logic [15:0] qv_q, qv_d;
`else
  logic        qval_unused;
  assign qval_unused = ^qval;
`endif

  logic [6:0]  cnt_eff;
  logic [10:0] slot_off;
  logic [7:0]  cnt_inc;

  // Stored counts above 64 are treated as a full table.
  assign cnt_eff  = count_q[6] ? 7'd64 : count_q;
  assign slot_off = {4'b0, slot_q, 1'b0};
  assign cnt_inc  = {1'b0, count_q} + 8'd1;

  always_comb begin
    state_d      = state_q;
    rd_ph_d      = rd_ph_q;
    count_d      = count_q;
    issue_d      = issue_q;
    cmp_vld_d    = cmp_vld_q;
    cmp_idx_d    = cmp_idx_q;
    append_d     = append_q;
    slot_d       = slot_q;
    full_d       = full_q;
    nbr_d        = nbr_q;
    cid_d        = cid_q;
    bat_d        = bat_q;
`ifdef NBR_QVALUE_WRITE_EN
    qv_d         = qv_q;
`endif
    mem.address  = 11'd0;
    mem.wr_en    = 1'b0;
    mem.data_out = 16'd0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && start) begin
          state_d = RD_CNT;
          rd_ph_d = 1'b0;
          nbr_d   = nbr_id;
          cid_d   = clus_id;
          bat_d   = batt;
`ifdef NBR_QVALUE_WRITE_EN
          qv_d    = qval;
`endif
          slot_d  = 6'd0;
          full_d  = 1'b0;
        end
      end
      RD_CNT: begin
        // First cycle presents the address, second cycle captures the returned word.
        mem.address = CNT_ADDR;
        if (!rd_ph_q) begin
          rd_ph_d = 1'b1;
        end else begin
          count_d   = mem.data_in[6:0];
          issue_d   = 7'd0;
          cmp_vld_d = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        // Pipelined: compare the word for index cmp_idx_q while issuing the next address.
        if (cmp_vld_q && (mem.data_in == nbr_q)) begin
          slot_d   = cmp_idx_q;
          append_d = 1'b0;
          state_d  = WR_NID;
        end else if (issue_q < cnt_eff) begin
          mem.address = NID_BASE + {4'b0, issue_q[5:0], 1'b0};
          cmp_vld_d   = 1'b1;
          cmp_idx_d   = issue_q[5:0];
          issue_d     = issue_q + 7'd1;
        end else if (count_q[6]) begin
          full_d  = 1'b1;
          state_d = DONE;
        end else begin
          slot_d   = count_q[5:0];
          append_d = 1'b1;
          state_d  = WR_NID;
        end
      end
      WR_NID: begin
        mem.wr_en    = 1'b1;
        mem.address  = NID_BASE + slot_off;
        mem.data_out = nbr_q;
        state_d      = WR_CID;
      end
      WR_CID: begin
        mem.wr_en    = 1'b1;
        mem.address  = CID_BASE + slot_off;
        mem.data_out = cid_q;
        state_d      = WR_BAT;
      end
      WR_BAT: begin
        mem.wr_en    = 1'b1;
        mem.address  = BAT_BASE + slot_off;
        mem.data_out = bat_q;
`ifdef NBR_QVALUE_WRITE_EN
        state_d      = WR_QV;
`else
        state_d      = append_q ? WR_CNT : DONE;
`endif
      end
`ifdef NBR_QVALUE_WRITE_EN
      WR_QV: begin
        mem.wr_en    = 1'b1;
        mem.address  = QV_BASE + slot_off;
        mem.data_out = qv_q;
        state_d      = append_q ? WR_CNT : DONE;
      end
`endif
      WR_CNT: begin
        mem.wr_en    = 1'b1;
        mem.address  = CNT_ADDR;
        mem.data_out = {8'd0, cnt_inc};
        state_d      = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (en && !start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_ph_q   <= 1'b0;
      count_q   <= 7'd0;
      issue_q   <= 7'd0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= 6'd0;
      append_q  <= 1'b0;
      slot_q    <= 6'd0;
      full_q    <= 1'b0;
      nbr_q     <= 16'd0;
      cid_q     <= 16'd0;
      bat_q     <= 16'd0;
`ifdef NBR_QVALUE_WRITE_EN
      qv_q      <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      rd_ph_q   <= rd_ph_d;
      count_q   <= count_d;
      issue_q   <= issue_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      append_q  <= append_d;
      slot_q    <= slot_d;
      full_q    <= full_d;
      nbr_q     <= nbr_d;
      cid_q     <= cid_d;
      bat_q     <= bat_d;
`ifdef NBR_QVALUE_WRITE_EN
      qv_q      <= qv_d;
`endif
    end
  end

  assign table_full = full_q;
  assign slot       = slot_q;
  assign state_dbg  = state_q;

endmodule
